// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, counting-mode enum and channel-index width helper
// for the pwm_multi block. Defining PWM_CENTER_ALIGN_EN selects centre-aligned
// counting; otherwise the block is edge-aligned only.
package pwm_pkg;

    localparam int NCH_DEF   = 4;
    localparam int WIDTH_DEF = 8;
    localparam int PSC_W_DEF = 8;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

`ifdef PWM_CENTER_ALIGN_EN
    localparam pwm_mode_e PWM_MODE = CENTER;
`else
    localparam pwm_mode_e PWM_MODE = EDGE;
`endif

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: duty-write bus of pwm_multi. The master issues duty writes,
// the slave (pwm_multi) returns ready and a one-cycle bad-channel error pulse.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int WIDTH = WIDTH_DEF
);

    localparam int CH_W = ch_w(NCH);

    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_err;

    modport master (
        output wr_valid, wr_ch, wr_duty,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_ch, wr_duty,
        output wr_ready, wr_err
    );

endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: turns clk into a one-cycle count-enable every prescale+1
// cycles while run is high; held at zero otherwise. No derived clocks.
module pwm_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;

    // >= rather than == so a prescale lowered mid-count still wraps at once.
    assign tick = run && (psc_cnt >= prescale);

    // Divider count: 0..prescale, cleared whenever the block is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (!run || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM with a shared prescaler and period counter,
// double-buffered per-channel duties and a period-boundary pulse.
// Optional macro PWM_CENTER_ALIGN_EN: up/down (centre-aligned) counting; in
// that mode the counter runs 0..period-1 up and back down to 0, so every
// value is visited twice per 2*period ticks and pulses are symmetric about 0.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [PSC_W-1:0] prescale,
    input  logic [WIDTH-1:0] period,
    pwm_multi_if.slave       wr,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_tick
);

    logic             ena_d;
    logic             run;
    logic             start;
    logic             tick;
    logic             boundary;
    logic             accept;
    logic             ch_ok;
    logic [31:0]      ch_idx;
    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] pend_duty [NCH];
    logic [WIDTH-1:0] act_duty  [NCH];
    logic [NCH-1:0]   pwm_p1;
    logic             ptick_p1;
    logic             err_p1;
`ifdef PWM_CENTER_ALIGN_EN
    logic             cnt_down;
    logic             at_peak;
`endif

    // start is the first enabled cycle (ena rising or first edge after reset);
    // it reloads period/duties, and compare output stays low for that cycle.
    assign run    = ena & ena_d;
    assign start  = ena & ~ena_d;
    assign accept = wr.wr_valid & ena;
    assign ch_idx = 32'(wr.wr_ch);
    assign ch_ok  = ch_idx < 32'(NCH);

    assign wr.wr_ready = ena;
    assign wr.wr_err   = err_p1;
    assign pwm_out     = pwm_p1;
    assign period_tick = ptick_p1;

    pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .prescale (prescale),
        .tick     (tick)
    );

`ifdef PWM_CENTER_ALIGN_EN
    assign at_peak  = (act_period == '0) || (cnt_p0 >= act_period - WIDTH'(1));
    assign boundary = tick && cnt_down && (cnt_p0 == '0);
`else
    assign boundary = tick && (cnt_p0 >= act_period);
`endif

    // ---- stage p0: period counter, active period/duty reload at boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0     <= '0;
            act_period <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            cnt_down   <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++) begin
                act_duty[i] <= '0;
            end
        end else if (!ena) begin
            cnt_p0   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            cnt_down <= 1'b0;
`endif
        end else if (start || boundary) begin
            cnt_p0     <= '0;
            act_period <= period;
`ifdef PWM_CENTER_ALIGN_EN
            cnt_down   <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++) begin
                act_duty[i] <= pend_duty[i];
            end
        end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (cnt_down) begin
                cnt_p0 <= cnt_p0 - WIDTH'(1);
            end else if (at_peak) begin
                cnt_down <= 1'b1;
            end else begin
                cnt_p0 <= cnt_p0 + WIDTH'(1);
            end
`else
            cnt_p0 <= cnt_p0 + WIDTH'(1);
`endif
        end
    end

    // Pending duties: an accepted in-range write lands here on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                pend_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept && (ch_idx == 32'(i))) begin
                    pend_duty[i] <= wr.wr_duty;
                end
            end
        end
    end

    // ---- stage p1: registered compare per channel, one cycle after counter
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic pwm_q;

        // Channel output high while the counter is below its active duty.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= run && (cnt_p0 < act_duty[g]);
            end
        end

        assign pwm_p1[g] = pwm_q;
    end

    // Status flags: enable history, boundary pulse, bad-channel write pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_d    <= 1'b0;
            ptick_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            ena_d    <= ena;
            ptick_p1 <= boundary;
            err_p1   <= accept && !ch_ok;
        end
    end

endmodule
